// File: rtl/capture_pkg.sv
// Shared widths and the writer state type for the capture memory writer.
package capture_pkg;

    localparam int unsigned WORD_BITS       = 256;
    localparam int unsigned WORD_BYTES      = 32;
    localparam int unsigned WORD_ADDR_SHIFT = 5;
    localparam int unsigned RING_W          = 24;
    localparam int unsigned COUNT_W         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wr_state_t;

endpackage

// File: rtl/capture_mem_writer_if.sv
// Avalon-MM write-master bundle between the capture writer and the SDRAM port.
interface capture_mem_writer_if
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    logic [ADDR_W-1:0]    avm_address;
    logic                 avm_write;
    logic [WORD_BITS-1:0] avm_writedata;
    logic                 avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_writedata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        output avm_waitrequest
    );

endinterface

// File: rtl/capture_word_fifo.sv
// Show-ahead synchronous word FIFO; the head is valid the cycle after a push.
module capture_word_fifo
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = WORD_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem[rd_q];
    // Full/empty come from the current count, so a same-cycle pop never admits a push.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PTR_W'(1);
            if (do_pop)  rd_d = rd_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/capture_mem_writer.sv
// Buffers capture words and writes them into a circular SDRAM ring via Avalon-MM.
module capture_mem_writer
    import capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [RING_W-1:0]      buf_words,
    input  logic                   in_valid,
    input  logic [WORD_BITS-1:0]   in_data,
    capture_mem_writer_if.master   avm,
    output logic                   busy,
    output logic                   wrapped,
    output logic                   overflow,
    output logic [COUNT_W-1:0]     words_written,
    output logic [RING_W-1:0]      wr_ptr
);

    localparam int unsigned FCNT_W = FIFO_DEPTH_LOG2 + 1;

    wr_state_t             state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [RING_W-1:0]     buf_q, buf_d;
    logic [RING_W-1:0]     ptr_q, ptr_d;
    logic                  wrapped_q, wrapped_d;
    logic                  overflow_q, overflow_d;
    logic [COUNT_W-1:0]    words_q, words_d;

    logic                  fifo_flush, fifo_push, fifo_full, fifo_empty;
    logic [WORD_BITS-1:0]  fifo_head;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  busy_c, write_c, accept_c;

    capture_word_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (WORD_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (accept_c),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign busy_c   = (state_q != IDLE);
    assign write_c  = busy_c && !fifo_empty;
    assign accept_c = write_c && !avm.avm_waitrequest;

    // Address and data are pure functions of registered state, so they hold across stalls.
    assign avm.avm_write     = write_c;
    assign avm.avm_writedata = write_c ? fifo_head : '0;
    assign avm.avm_address   = base_q + (ADDR_W'(ptr_q) << WORD_ADDR_SHIFT);

    assign busy          = busy_c;
    assign wrapped       = wrapped_q;
    assign overflow      = overflow_q;
    assign words_written = words_q;
    assign wr_ptr        = ptr_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        wrapped_d  = wrapped_q;
        overflow_d = overflow_q;
        words_d    = words_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !stop && (buf_words != '0)) begin
                    state_d    = RUN;
                    base_d     = base_addr;
                    buf_d      = buf_words;
                    ptr_d      = '0;
                    wrapped_d  = 1'b0;
                    overflow_d = 1'b0;
                    words_d    = '0;
                    fifo_flush = 1'b1;
                end
            end
            RUN: begin
                fifo_push = in_valid;
                if (in_valid && fifo_full) overflow_d = 1'b1;
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_count == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance only happens while busy, so it never collides with the start clear.
        if (accept_c) begin
            words_d = words_q + COUNT_W'(1);
            if (ptr_q == buf_q - RING_W'(1)) begin
                ptr_d     = '0;
                wrapped_d = 1'b1;
            end else begin
                ptr_d = ptr_q + RING_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            buf_q      <= '0;
            ptr_q      <= '0;
            wrapped_q  <= 1'b0;
            overflow_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            buf_q      <= buf_d;
            ptr_q      <= ptr_d;
            wrapped_q  <= wrapped_d;
            overflow_q <= overflow_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_capture_mem_writer.sv
// Directed plus randomized bench for capture_mem_writer against a queue-based ring model.
module tb_capture_mem_writer;
    import capture_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, in_valid;
    logic [31:0]   base_addr;
    logic [23:0]   buf_words;
    logic [255:0]  in_data;
    logic          busy, wrapped, overflow;
    logic [31:0]   words_written;
    logic [23:0]   wr_ptr;

    capture_mem_writer_if avm_bus ();

    capture_mem_writer #(.FIFO_DEPTH_LOG2(4), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .base_addr     (base_addr),
        .buf_words     (buf_words),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .avm           (avm_bus.master),
        .busy          (busy),
        .wrapped       (wrapped),
        .overflow      (overflow),
        .words_written (words_written),
        .wr_ptr        (wr_ptr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: a run is either idle, collecting (active) or finishing (draining).
    bit            m_active, m_draining;
    logic [255:0]  m_q[$];
    logic [31:0]   m_base;
    logic [23:0]   m_ring, m_ptr;
    logic [31:0]   m_count;
    bit            m_wrapped, m_ov;

    logic [31:0]   log_addr[$];
    logic [255:0]  log_data[$];
    logic [255:0]  sent[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic bit m_busy();
        return m_active || m_draining;
    endfunction

    function automatic bit m_write();
        return m_busy() && (m_q.size() != 0);
    endfunction

    task automatic model_reset();
        m_active = 0; m_draining = 0; m_q.delete();
        m_base = 0; m_ring = 0; m_ptr = 0; m_count = 0; m_wrapped = 0; m_ov = 0;
    endtask

    task automatic compare();
        logic [31:0] exp_addr;
        exp_addr = m_base + (32'(m_ptr) * 32'd32);
        check("busy", 256'(busy), 256'(m_busy()));
        check("avm_write", 256'(avm_bus.avm_write), 256'(m_write()));
        check("avm_address", 256'(avm_bus.avm_address), 256'(exp_addr));
        check("avm_writedata", avm_bus.avm_writedata, m_write() ? m_q[0] : 256'(0));
        check("wrapped", 256'(wrapped), 256'(m_wrapped));
        check("overflow", 256'(overflow), 256'(m_ov));
        check("words_written", 256'(words_written), 256'(m_count));
        check("wr_ptr", 256'(wr_ptr), 256'(m_ptr));
        if (avm_bus.avm_write && !avm_bus.avm_waitrequest) begin
            log_addr.push_back(avm_bus.avm_address);
            log_data.push_back(avm_bus.avm_writedata);
        end
    endtask

    task automatic model_update();
        bit acc, was_empty, was_full;
        if (rst) begin
            model_reset();
            return;
        end
        acc       = m_write() && !avm_bus.avm_waitrequest;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == 16);
        if (!m_busy()) begin
            if (start && !stop && buf_words != 0) begin
                m_active = 1; m_base = base_addr; m_ring = buf_words;
                m_ptr = 0; m_count = 0; m_wrapped = 0; m_ov = 0; m_q.delete();
            end
        end else begin
            if (acc) begin
                void'(m_q.pop_front());
                m_count = m_count + 1;
                if (32'(m_ptr) + 1 == 32'(m_ring)) begin
                    m_ptr = 0; m_wrapped = 1;
                end else begin
                    m_ptr = m_ptr + 1;
                end
            end
            if (m_active) begin
                if (in_valid) begin
                    if (was_full) m_ov = 1;
                    else m_q.push_back(in_data);
                end
                if (stop) begin m_active = 0; m_draining = 1; end
            end else if (was_empty) begin
                m_draining = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [23:0] words);
        base_addr = base; buf_words = words; start = 1;
        step();
        start = 0;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) begin
            in_data = rand_word(); sent.push_back(in_data); in_valid = 1;
            step();
        end
        in_valid = 0;
    endtask

    task automatic stop_and_drain();
        stop = 1; step(); stop = 0;
        for (int k = 0; k < 60 && m_busy(); k++) step();
        step();
        check("drain_idle", 256'(busy), 256'(0));
    endtask

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); sent.delete();
    endtask

    logic [31:0] t1_addr [6];
    logic [31:0] held_addr;
    logic [255:0] held_data;

    initial begin
        rst = 1; start = 0; stop = 0; in_valid = 0; in_data = '0;
        base_addr = '0; buf_words = '0; avm_bus.avm_waitrequest = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        step();
        check("reset_write", 256'(avm_bus.avm_write), 256'(0));
        rst = 0;
        step();

        // Ring of 4 words, 6 writes: wraps once and ends at index 2.
        t1_addr = '{32'h1000_0000, 32'h1000_0020, 32'h1000_0040,
                    32'h1000_0060, 32'h1000_0000, 32'h1000_0020};
        clear_logs();
        pulse_start(32'h1000_0000, 24'd4);
        push_words(6);
        repeat (3) step();
        check("t1_nwrites", 256'(log_addr.size()), 256'(6));
        for (int i = 0; i < 6; i++) begin
            check("t1_addr", 256'(log_addr[i]), 256'(t1_addr[i]));
            check("t1_data", log_data[i], sent[i]);
        end
        check("t1_count", 256'(words_written), 256'(6));
        check("t1_ptr", 256'(wr_ptr), 256'(2));
        check("t1_wrapped", 256'(wrapped), 256'(1));
        stop_and_drain();

        // Three stall cycles hold address and data and do not count.
        clear_logs();
        pulse_start(32'h2000_0000, 24'd8);
        avm_bus.avm_waitrequest = 1;
        push_words(1);
        held_addr = avm_bus.avm_address; held_data = avm_bus.avm_writedata;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold_addr", 256'(avm_bus.avm_address), 256'(held_addr));
            check("t2_hold_data", avm_bus.avm_writedata, held_data);
            check("t2_no_count", 256'(words_written), 256'(0));
        end
        avm_bus.avm_waitrequest = 0;
        step();
        step();
        check("t2_count", 256'(words_written), 256'(1));
        check("t2_data", log_data[0], sent[0]);
        stop_and_drain();

        // Twenty words into a 16-deep FIFO under stall.
        clear_logs();
        pulse_start(32'h0400_0000, 24'd32);
        avm_bus.avm_waitrequest = 1;
        push_words(20);
        step();
        check("t3_overflow", 256'(overflow), 256'(1));
        avm_bus.avm_waitrequest = 0;
        repeat (20) step();
        check("t3_count", 256'(words_written), 256'(16));
        check("t3_nwrites", 256'(log_data.size()), 256'(16));
        for (int i = 0; i < 16; i++) check("t3_data", log_data[i], sent[i]);
        stop_and_drain();

        // Stop with three words queued while input keeps streaming.
        clear_logs();
        pulse_start(32'h0800_0000, 24'd16);
        avm_bus.avm_waitrequest = 1;
        push_words(2);
        in_valid = 1; in_data = rand_word(); stop = 1;
        step();
        stop = 0;
        avm_bus.avm_waitrequest = 0;
        for (int k = 0; k < 20 && m_busy(); k++) begin in_data = rand_word(); step(); end
        repeat (4) begin in_data = rand_word(); step(); end
        in_valid = 0;
        check("t4_busy", 256'(busy), 256'(0));
        check("t4_count", 256'(words_written), 256'(3));
        check("t4_overflow", 256'(overflow), 256'(0));

        // Reset in the middle of a stalled write.
        clear_logs();
        pulse_start(32'h0C00_0000, 24'd16);
        avm_bus.avm_waitrequest = 1;
        push_words(2);
        step();
        rst = 1; step(); rst = 0;
        avm_bus.avm_waitrequest = 0;
        step();
        check("t5_write", 256'(avm_bus.avm_write), 256'(0));
        check("t5_busy", 256'(busy), 256'(0));
        check("t5_count", 256'(words_written), 256'(0));
        clear_logs();
        pulse_start(32'h3000_0000, 24'd2);
        push_words(1);
        step();
        check("t5_nwrites", 256'(log_addr.size()), 256'(1));
        check("t5_addr", 256'(log_addr[0]), 256'(32'h3000_0000));
        stop_and_drain();

        // Ignored starts.
        pulse_start(32'h0000_1000, 24'd0);
        step();
        check("t6_zero_ring", 256'(busy), 256'(0));
        stop = 1; pulse_start(32'h0000_1000, 24'd4); stop = 0;
        step();
        check("t6_start_stop", 256'(busy), 256'(0));
        pulse_start(32'h0000_2000, 24'd8);
        push_words(2);
        step();
        pulse_start(32'h0000_4000, 24'd8);
        step();
        check("t6_restart_count", 256'(words_written), 256'(2));
        check("t6_restart_ptr", 256'(wr_ptr), 256'(2));
        stop_and_drain();

        // Randomized traffic: random ring sizes, stalls, bursts and control pulses.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            base_addr = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
            buf_words = 24'($urandom_range(0, 6));
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = rand_word();
            avm_bus.avm_waitrequest = ($urandom_range(0, 9) < 3);
            step();
        end
        rst = 0; start = 0; stop = 0; in_valid = 0; avm_bus.avm_waitrequest = 0;
        stop_and_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_mem_writer.md
Name: capture_mem_writer

Overview:
Downstream consumer of the channel-mapper stage. It takes packed 256-bit capture words and their valid strobe, and buffers them in a small FIFO. It then writes them through an Avalon-MM master into a circular capture buffer in DE10 SDRAM. Start/stop control, wrap tracking, an overflow flag and a write count are exposed to the control/CSR logic.

Parameters:
FIFO_DEPTH_LOG2, 4, log2 of the word FIFO depth (default 16 words)
ADDR_W, 32, Avalon byte-address width

Ports:
clk  input  1  capture clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; arms a capture run
stop  input  1  single-cycle pulse; ends the run and drains the FIFO
base_addr  input  ADDR_W  byte address of ring word 0; must be 32-byte aligned; latched on start
buf_words  input  24  ring size in 256-bit words; latched on start
in_valid  input  1  in_data holds a new capture word
in_data  input  256  packed capture word
avm_address  output  ADDR_W  byte address of the current write
avm_write  output  1  write request
avm_writedata  output  256  write data
avm_waitrequest  input  1  slave stall
busy  output  1  high in RUN or DRAIN
wrapped  output  1  sticky; ring pointer has wrapped at least once in this run
overflow  output  1  sticky; at least one input word was dropped in this run
words_written  output  32  Avalon writes completed in this run; wraps modulo 2^32
wr_ptr  output  24  ring index of the next write

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE and the FIFO is flushed.
  - All outputs are 0: avm_*, busy, wrapped, overflow, words_written, wr_ptr.
  - Reset asserted mid-transfer abandons the transfer immediately. No handshake completion is owed.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1, stop=0 and buf_words!=0 → RUN.
  - On that transition: latch base_addr and buf_words; clear wrapped, overflow, words_written and wr_ptr; flush the FIFO.
  - start with buf_words==0 is ignored.
  - start and stop in the same cycle: stop wins and the FSM stays in IDLE.
  - stop alone is ignored.
- RUN:
  - in_valid=1 with FIFO not full → push in_data.
  - in_valid=1 with FIFO full → word dropped and overflow set. Full is evaluated on the current count, so a same-cycle pop does not rescue the push.
  - stop → DRAIN. A word presented in the same cycle as stop is still pushed.
  - start is ignored.
- DRAIN:
  - in_valid is ignored; it is neither pushed nor counted as overflow.
  - FIFO empty and no write pending → IDLE.
- IDLE: in_valid is ignored.
- FIFO: synchronous, show-ahead. A word pushed at edge N is at the head in cycle N+1.
- Avalon write:
  - avm_write = busy && FIFO not empty.
  - avm_writedata = FIFO head.
  - avm_address = base_latched + wr_ptr*32.
  - Address and data are held stable while avm_waitrequest=1.
- Write acceptance (avm_write && !avm_waitrequest), each such cycle:
  - pop the FIFO;
  - words_written += 1;
  - if wr_ptr == buf_latched-1, set wr_ptr=0 and wrapped=1; otherwise wr_ptr += 1.
- Latency: a word presented in cycle N, with an empty FIFO and waitrequest low, is written in cycle N+1. Throughput is one word per cycle.
- Address arithmetic: wr_ptr*32 is computed as a left shift by 5, zero-extended to ADDR_W. A sum that overflows ADDR_W wraps; that is a software configuration error.
- Flags: wrapped, overflow and words_written hold their values after returning to IDLE until the next accepted start.

Decomposition:
- Package capture_pkg:
  - WORD_BITS=256, WORD_BYTES=32, WORD_ADDR_SHIFT=5;
  - typedef enum wr_state_t {IDLE, RUN, DRAIN};
  - RING_W=24.
- Sub-module capture_word_fifo:
  - parameterised show-ahead synchronous FIFO (256-bit width, 2^FIFO_DEPTH_LOG2 depth);
  - push/pop/full/empty/count; synchronous rst flush.
- FSM, pointer and Avalon logic stay in capture_mem_writer.

Test Plan:
1. base=0x1000_0000, buf_words=4, start, 6 consecutive words, waitrequest=0 → addresses 0x1000_0000, 0x1000_0020, 0x1000_0040, 0x1000_0060, 0x1000_0000, 0x1000_0020; data in order; wrapped rises on the 4th acceptance; words_written=6; wr_ptr=2.
2. waitrequest held high for 3 cycles during a write → address and data unchanged over those cycles, no pop, words_written increments only on the release cycle.
3. FIFO_DEPTH_LOG2=4, waitrequest high, 20 input words → first 16 stored, overflow=1; after release exactly 16 writes carrying words 0–15.
4. stop with 3 words queued, in_valid continuously high → busy stays 1 until the 3 writes complete, then IDLE; no further words written; overflow remains 0.
5. rst asserted during a stalled write → next cycle avm_write=0, busy=0, all counters 0; a following start with 1 word writes to base_addr.
6. start with buf_words=0 → stays IDLE, busy=0. start+stop in the same cycle → stays IDLE. start during RUN → counters not cleared.
